btb_update_ctrl: RTL and testbench
==================================

Name: btb_update_ctrl

Overview:
- Sequences all writes into the 64-entry direct-mapped branch target buffer (BTB).
- Queues resolved taken non-jalr branches from EX in a small FIFO and issues them one per cycle to the single BTB write port when granted.
- Runs a flush sweep that invalidates every BTB index. Prediction lookups are gated off while the sweep runs.
- Sits between the EX stage, the BTB write/invalidate port and the IF-stage prediction logic.

Parameters:
- QDEPTH, 4, update FIFO depth (power of two, >=2).
- ENTRIES, 64, number of BTB rows covered by the sweep.
- IDX_W, 6, log2(ENTRIES); width of the BTB index, taken from PC[IDX_W+1:2].

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous active-low reset.
- ex_valid  in  1  EX holds a resolved control-transfer instruction this cycle.
- ex_taken  in  1  the branch resolved taken.
- ex_is_jalr  in  1  the instruction is jalr; never written to the BTB.
- ex_pc  in  32  PC of the resolved instruction.
- ex_target  in  32  resolved target address.
- flush_req  in  1  one-cycle request to invalidate the whole BTB.
- btb_wr_gnt  in  1  the shared BTB write port accepts the update this cycle.
- btb_wr_en  out  1  update request; must be held stable until granted.
- btb_wr_pc  out  32  PC to write (tag and index are derived inside the BTB).
- btb_wr_addr  out  32  target to write.
- btb_inv_en  out  1  invalidate the valid bit at btb_inv_idx.
- btb_inv_idx  out  IDX_W  row being invalidated.
- btb_lookup_en  out  1  IF may use the BTB hit; 0 during the sweep.
- upd_full  out  1  FIFO count == QDEPTH.
- upd_drop  out  1  one-cycle pulse: an eligible update was discarded.
- busy  out  1  state != IDLE.

Behaviour:
- Reset (rst_n=0 at a clock edge, from any state, including mid-sweep):
  - FIFO emptied, pointers and count 0, state IDLE, sweep index 0.
  - All outputs 0 except btb_lookup_en=1.
- Eligible update: ex_valid & ex_taken & ~ex_is_jalr.
- States:
  - IDLE: FIFO empty, no sweep in progress.
  - DRAIN: FIFO non-empty.
  - SWEEP: invalidating BTB rows.
- Transitions:
  - IDLE -> DRAIN on an accepted push.
  - DRAIN -> IDLE when the last entry pops with no push in the same cycle.
  - Any state -> SWEEP on flush_req; flush_req has top priority.
  - SWEEP -> IDLE after row ENTRIES-1 is invalidated.
- DRAIN:
  - btb_wr_en=1; btb_wr_pc and btb_wr_addr come combinationally from the FIFO head.
  - Pop only in a cycle where btb_wr_en & btb_wr_gnt; otherwise the head is held unchanged.
- Push acceptance:
  - An eligible update is accepted if count<QDEPTH, or if a pop occurs in the same cycle (simultaneous push/pop when full is allowed).
  - Otherwise the update is dropped and upd_drop=1 for the cycle following the attempt.
- Latency: a push at edge N into an empty FIFO gives btb_wr_en=1 during cycle N+1.
- FIFO wrap: pointers are modulo QDEPTH; count is 0..QDEPTH.
- flush_req at edge N:
  - FIFO is cleared at edge N, including any push presented that cycle.
  - Sweep index is set to 0 and state becomes SWEEP.
- SWEEP:
  - btb_inv_en=1 and btb_inv_idx=index every cycle; btb_wr_gnt is ignored (the sweep owns the port).
  - Index increments by 1 per cycle, so the sweep lasts exactly ENTRIES cycles.
  - btb_wr_en=0 and btb_lookup_en=0 for the whole sweep.
  - Eligible updates are dropped silently (upd_drop stays 0).
- flush_req during SWEEP restarts the index at 0.
- btb_wr_en and btb_inv_en are never 1 in the same cycle.

Optional Feature:
- Macro: BTB_UPD_MERGE_EN.
- Defined:
  - An eligible push whose ex_pc equals the PC of the most recently enqueued, still-queued entry overwrites that entry's target instead of taking a new slot.
  - No count change and no drop, even when full.
  - Exception: if that entry is the head and is being popped this cycle, it is a normal push.
- Undefined: every eligible update takes its own slot.

Test Plan:
- Reset, then one eligible push (pc=0x0000_0100, tgt=0x0000_0200), gnt=1 -> btb_wr_en=1 one cycle later with those values, then IDLE, busy=0.
- gnt=0, push 4 distinct branches, then a 5th -> upd_full=1; 5th dropped with upd_drop pulse; raising gnt drains the 4 in FIFO order over 4 cycles.
- Full FIFO with gnt=1 and a simultaneous push -> push accepted, count stays 4, no drop.
- flush_req with 2 entries queued -> FIFO cleared; btb_inv_idx steps 0..63 over 64 cycles with btb_lookup_en=0; then IDLE, lookup_en=1.
- flush_req at inv_idx=30, then rst_n=0 at idx 10 of the restarted sweep -> index restarts at 0 on the flush; reset yields IDLE, all outputs 0, lookup_en=1.
- jalr taken and not-taken branches -> no push. With BTB_UPD_MERGE_EN and gnt=0, the same pc pushed twice -> count 1, target = second value.

Source files
------------

// File: rtl/btb_update_ctrl_if.sv
// Signal bundle between EX, the BTB write/invalidate port, IF prediction and btb_update_ctrl.
// master = environment side, slave = the update controller.
interface btb_update_ctrl_if #(
  parameter int IDX_W = 6
);
  logic             ex_valid;
  logic             ex_taken;
  logic             ex_is_jalr;
  logic [31:0]      ex_pc;
  logic [31:0]      ex_target;
  logic             flush_req;
  logic             btb_wr_gnt;
  logic             btb_wr_en;
  logic [31:0]      btb_wr_pc;
  logic [31:0]      btb_wr_addr;
  logic             btb_inv_en;
  logic [IDX_W-1:0] btb_inv_idx;
  logic             btb_lookup_en;
  logic             upd_full;
  logic             upd_drop;
  logic             busy;

  modport master (
    output ex_valid, ex_taken, ex_is_jalr, ex_pc, ex_target, flush_req, btb_wr_gnt,
    input  btb_wr_en, btb_wr_pc, btb_wr_addr, btb_inv_en, btb_inv_idx,
           btb_lookup_en, upd_full, upd_drop, busy
  );

  modport slave (
    input  ex_valid, ex_taken, ex_is_jalr, ex_pc, ex_target, flush_req, btb_wr_gnt,
    output btb_wr_en, btb_wr_pc, btb_wr_addr, btb_inv_en, btb_inv_idx,
           btb_lookup_en, upd_full, upd_drop, busy
  );
endinterface

// File: rtl/btb_update_ctrl.sv
// BTB write sequencer: update FIFO drained through the shared write port, plus a full-BTB flush sweep.
// Optional macro BTB_UPD_MERGE_EN: a push matching the youngest queued PC overwrites its target.
module btb_update_ctrl #(
  parameter int QDEPTH  = 4,
  parameter int ENTRIES = 64,
  parameter int IDX_W   = 6
) (
  input  logic            clk,
  input  logic            rst_n,
  btb_update_ctrl_if.slave bus
);
  localparam int PTR_W = $clog2(QDEPTH);
  localparam int CNT_W = $clog2(QDEPTH + 1);

  typedef enum logic [1:0] {S_IDLE, S_DRAIN, S_SWEEP} state_t;

  state_t           state_q, state_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] last_ptr;
  logic [CNT_W-1:0] count_q, count_d;
  logic [IDX_W-1:0] sweep_idx_q, sweep_idx_d;
  logic             drop_q, drop_d;

  logic [31:0] pc_mem  [QDEPTH];
  logic [31:0] tgt_mem [QDEPTH];

  logic              eligible;
  logic              pop;
  logic              push;
  logic              merge_hit;
  logic              full;
  logic [QDEPTH-1:0] slot_pc_we;
  logic [QDEPTH-1:0] slot_tgt_we;

  assign eligible = bus.ex_valid & bus.ex_taken & ~bus.ex_is_jalr;
  assign pop      = (state_q == S_DRAIN) & bus.btb_wr_gnt;
  assign full     = (count_q == CNT_W'(QDEPTH));
  assign last_ptr = wr_ptr_q - PTR_W'(1);

`ifdef BTB_UPD_MERGE_EN
  // The head leaving this cycle cannot absorb a merge; the push then takes a fresh slot.
  assign merge_hit = eligible & ~bus.flush_req & (state_q == S_DRAIN)
                   & (pc_mem[last_ptr] == bus.ex_pc)
                   & ~(pop & (count_q == CNT_W'(1)));
`else
  assign merge_hit = 1'b0;
`endif

  assign push = eligible & ~bus.flush_req & (state_q != S_SWEEP) & ~merge_hit
              & (~full | pop);

  for (genvar gi = 0; gi < QDEPTH; gi++) begin : g_slot_we
    assign slot_pc_we[gi]  = push & (wr_ptr_q == PTR_W'(gi));
    assign slot_tgt_we[gi] = slot_pc_we[gi] | (merge_hit & (last_ptr == PTR_W'(gi)));
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < QDEPTH; i++) begin
      if (slot_pc_we[i])  pc_mem[i]  <= bus.ex_pc;
      if (slot_tgt_we[i]) tgt_mem[i] <= bus.ex_target;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      sweep_idx_q <= '0;
      drop_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      sweep_idx_q <= sweep_idx_d;
      drop_q      <= drop_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    sweep_idx_d = sweep_idx_q;
    drop_d      = 1'b0;
    if (bus.flush_req) begin
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      count_d     = '0;
      sweep_idx_d = '0;
      state_d     = S_SWEEP;
    end else begin
      case (state_q)
        S_SWEEP: begin
          if (sweep_idx_q == IDX_W'(ENTRIES - 1)) begin
            sweep_idx_d = '0;
            state_d     = S_IDLE;
          end else begin
            sweep_idx_d = sweep_idx_q + IDX_W'(1);
          end
        end
        default: begin
          if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
          if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
          if (push & ~pop)      count_d = count_q + CNT_W'(1);
          else if (pop & ~push) count_d = count_q - CNT_W'(1);
          drop_d  = eligible & ~push & ~merge_hit;
          state_d = (count_d != '0) ? S_DRAIN : S_IDLE;
        end
      endcase
    end
  end

  assign bus.btb_wr_en     = (state_q == S_DRAIN);
  assign bus.btb_wr_pc     = bus.btb_wr_en ? pc_mem[rd_ptr_q]  : '0;
  assign bus.btb_wr_addr   = bus.btb_wr_en ? tgt_mem[rd_ptr_q] : '0;
  assign bus.btb_inv_en    = (state_q == S_SWEEP);
  assign bus.btb_inv_idx   = bus.btb_inv_en ? sweep_idx_q : '0;
  assign bus.btb_lookup_en = ~bus.btb_inv_en;
  assign bus.upd_full      = full;
  assign bus.upd_drop      = drop_q;
  assign bus.busy          = (state_q != S_IDLE);
endmodule

// File: tb/tb_btb_update_ctrl.sv
// Scoreboard bench for btb_update_ctrl: accepted pushes are queued, popped and compared on each granted write.
module tb_btb_update_ctrl;
  localparam int QDEPTH  = 4;
  localparam int ENTRIES = 64;
  localparam int IDX_W   = 6;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] tgt;
  } ent_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total_cnt = 0;
  int   bad_cnt = 0;

  ent_t             sbq[$];
  bit               m_sweep = 1'b0;
  logic [IDX_W-1:0] m_idx = '0;
  bit               m_drop = 1'b0;

  always #5 clk = ~clk;

  btb_update_ctrl_if #(.IDX_W(IDX_W)) bif();

  btb_update_ctrl #(.QDEPTH(QDEPTH), .ENTRIES(ENTRIES), .IDX_W(IDX_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bif.slave)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total_cnt++;
    if (obs !== exp_v) begin
      bad_cnt++;
      $display("FAIL %s obs=%h exp=%h t=%0t", tag, obs, exp_v, $time);
    end
  endtask

  // Reference model and checker, evaluated mid-cycle while inputs are stable.
  always @(negedge clk) begin
    bit exp_wr, do_pop, elig, do_merge;
    int sz;
    sz     = sbq.size();
    exp_wr = !m_sweep && (sz != 0);
    chk("wr_en", bif.btb_wr_en, exp_wr);
    chk("wr_pc",   bif.btb_wr_pc,   exp_wr ? sbq[0].pc  : 32'h0);
    chk("wr_addr", bif.btb_wr_addr, exp_wr ? sbq[0].tgt : 32'h0);
    chk("inv_en",  bif.btb_inv_en,  m_sweep);
    chk("inv_idx", bif.btb_inv_idx, m_sweep ? m_idx : '0);
    chk("lookup_en", bif.btb_lookup_en, !m_sweep);
    chk("upd_full",  bif.upd_full, sz == QDEPTH);
    chk("upd_drop",  bif.upd_drop, m_drop);
    chk("busy",      bif.busy, m_sweep || (sz != 0));

    do_pop = exp_wr && bif.btb_wr_gnt;
    if (do_pop) $display("xfer pc=%h tgt=%h", sbq[0].pc, sbq[0].tgt);
    elig = bif.ex_valid && bif.ex_taken && !bif.ex_is_jalr;
    m_drop = 1'b0;
    if (!rst_n) begin
      sbq.delete();
      m_sweep = 1'b0;
      m_idx   = '0;
    end else if (bif.flush_req) begin
      sbq.delete();
      m_sweep = 1'b1;
      m_idx   = '0;
    end else if (m_sweep) begin
      if (m_idx == IDX_W'(ENTRIES - 1)) begin
        m_sweep = 1'b0;
        m_idx   = '0;
      end else begin
        m_idx = m_idx + 1'b1;
      end
    end else begin
      do_merge = 1'b0;
`ifdef BTB_UPD_MERGE_EN
      if (elig && sz != 0)
        do_merge = (sbq[sz-1].pc == bif.ex_pc) && !(do_pop && sz == 1);
`endif
      if (do_pop) void'(sbq.pop_front());
      if (do_merge) begin
        sbq[sbq.size()-1].tgt = bif.ex_target;
      end else if (elig) begin
        if (sbq.size() < QDEPTH) sbq.push_back('{pc: bif.ex_pc, tgt: bif.ex_target});
        else m_drop = 1'b1;
      end
    end
  end

  task automatic drv(input bit v, input bit t, input bit j, input logic [31:0] pc,
                     input logic [31:0] tgt, input bit fl, input bit g);
    bif.ex_valid   = v;
    bif.ex_taken   = t;
    bif.ex_is_jalr = j;
    bif.ex_pc      = pc;
    bif.ex_target  = tgt;
    bif.flush_req  = fl;
    bif.btb_wr_gnt = g;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n, input bit g);
    for (int i = 0; i < n; i++) drv(0, 0, 0, 32'h0, 32'h0, 0, g);
  endtask

  initial begin
    bif.ex_valid = 0; bif.ex_taken = 0; bif.ex_is_jalr = 0;
    bif.ex_pc = '0; bif.ex_target = '0; bif.flush_req = 0; bif.btb_wr_gnt = 0;
    rst_n = 1'b0;
    idle(2, 0);
    rst_n = 1'b1;
    idle(1, 0);

    // single push, granted immediately
    drv(1, 1, 0, 32'h0000_0100, 32'h0000_0200, 0, 1);
    idle(3, 1);

    // fill to full, overflow drop, then drain in order
    for (int i = 0; i < 5; i++) drv(1, 1, 0, 32'h1000 + 32'(i * 4), 32'h9000 + 32'(i), 0, 0);
    idle(2, 0);
    idle(6, 1);

    // full with simultaneous push and pop
    for (int i = 0; i < 4; i++) drv(1, 1, 0, 32'h2000 + 32'(i * 4), 32'hA000 + 32'(i), 0, 0);
    drv(1, 1, 0, 32'h2100, 32'hA100, 0, 1);
    idle(6, 1);

    // flush with entries queued, full sweep
    drv(1, 1, 0, 32'h3000, 32'hB000, 0, 0);
    drv(1, 1, 0, 32'h3004, 32'hB004, 0, 0);
    drv(1, 1, 0, 32'h3008, 32'hB008, 1, 0);
    idle(ENTRIES + 4, 1);

    // flush restart mid-sweep, then reset mid-sweep
    drv(0, 0, 0, 32'h0, 32'h0, 1, 0);
    idle(30, 0);
    drv(0, 0, 0, 32'h0, 32'h0, 1, 0);
    idle(10, 0);
    rst_n = 1'b0;
    idle(1, 0);
    rst_n = 1'b1;
    idle(2, 0);

    // ineligible updates
    drv(1, 1, 1, 32'h4000, 32'hC000, 0, 0);
    drv(1, 0, 0, 32'h4004, 32'hC004, 0, 0);
    drv(0, 1, 0, 32'h4008, 32'hC008, 0, 0);
    idle(2, 0);

    // same pc twice while stalled
    drv(1, 1, 0, 32'h5000, 32'hD000, 0, 0);
    drv(1, 1, 0, 32'h5000, 32'hD111, 0, 0);
    idle(2, 0);
    idle(4, 1);

    // random mix with a small pc set to provoke merges and overflow
    for (int i = 0; i < 400; i++) begin
      drv($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0,
          32'h6000 + 32'($urandom_range(0, 3) * 4), $urandom, $urandom_range(0, 120) == 0,
          $urandom_range(0, 2) == 0);
    end
    idle(ENTRIES + 8, 1);

    @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end
endmodule
